dekodier_steuerwerk: RTL and testbench
======================================

// Module: dekodier_steuerwerk
// PURPOSE
//   Sequencer in front of the instruction decoder. Accepts fetched words, pulses DekodierSignal.
//   Holds each decoded instruction until its 6-bit source/target registers are free (64-entry scoreboard).
//   Then issues it to execute and tracks pending writes until writeback.
//   Blocks further fetch while a jump is unresolved.
// PARAMETERS
//   REG_ANZAHL      64   scoreboard entries; register-index width is clog2(REG_ANZAHL) = 6
//   ZAEHLER_BREITE  32   width of stall counter (only with STALL_ZAEHLER_EN)
// PORTS
//   Clock                    in   1   single clock, all logic on posedge
//   Reset                    in   1   synchronous, active-low (0 = reset)
//   InstruktionGueltig       in   1   fetch presents a valid instruction word
//   FetchBereit              out  1   controller can accept an instruction this cycle
//   DekodierSignal           out  1   decoder latches Instruktion at this clock edge
//   QuellRegister1/2         in   6   decoder source indices (valid in state DEKODIERT)
//   ZielRegister             in   6   decoder target index
//   LoadBefehl, StoreBefehl  in   1   decoder class flags
//   JALBefehl                in   1   decoder class flag
//   UnbedingterSprungBefehl  in   1   decoder class flag
//   BedingterSprungBefehl    in   1   decoder class flag
//   AusfuehrenSignal         out  1   one-cycle issue pulse to execute stage
//   Stall                    out  1   decoded instruction held by a hazard
//   RueckschreibGueltig      in   1   writeback of RueckschreibRegister this cycle
//   RueckschreibRegister     in   6   register being written back
//   SprungAufgeloest         in   1   execute has resolved the outstanding jump
//   StallAnzahl              out  ZAEHLER_BREITE   stall-cycle count (only with STALL_ZAEHLER_EN)
// BEHAVIOUR
//   FSM states: BEREIT, DEKODIERT, SPRUNG. Scoreboard Belegt[63:0]; index 0 is never busy.
//   Reset (Reset==0 at posedge):
//     - state -> BEREIT; Belegt -> 0; StallAnzahl -> 0.
//     - All outputs are forced 0 while Reset==0. Applies mid-operation; any held instruction is dropped.
//   BEREIT:
//     - FetchBereit=1; DekodierSignal = InstruktionGueltig (combinational).
//     - If InstruktionGueltig: -> DEKODIERT. Otherwise stay.
//   DEKODIERT:
//     - Belegt_eff = Belegt with bit RueckschreibRegister cleared when RueckschreibGueltig.
//       This bypasses the clear so issue can occur in the writeback cycle.
//     - Hazard = Belegt_eff[Q1] | Belegt_eff[Q2] | Belegt_eff[Z] (RAW and WAW).
//     - Hazard: Stall=1; stay in DEKODIERT; decoder holds, DekodierSignal=0.
//     - No hazard: AusfuehrenSignal=1 for exactly this cycle.
//       - Next state: if UnbedingterSprungBefehl|BedingterSprungBefehl -> SPRUNG; else -> BEREIT.
//   SPRUNG:
//     - FetchBereit=0 until SprungAufgeloest=1 -> BEREIT. Next fetch is accepted one cycle later.
//   Scoreboard set on issue:
//     - Belegt[Z] <= 1 when Z!=0 && !StoreBefehl && !(jump && !JALBefehl).
//     - Stores, Jmp, Bez and Jreg reserve nothing; JAL reserves its link register.
//   Scoreboard clear: RueckschreibGueltig clears Belegt[RueckschreibRegister] in any state.
//   Simultaneous set and clear of the same index: set wins.
//   Writeback to an index not busy: no effect; no error flag.
//   Latency: accept in cycle n; issue in n+1 if no hazard; max throughput 1 instruction per 2 cycles.
//   SprungAufgeloest outside SPRUNG is ignored.
// CONFIGURATION
//   STALL_ZAEHLER_EN
//     - Defined: StallAnzahl increments each cycle Stall=1. Saturates at all-ones; cleared only by reset.
//     - Undefined: port StallAnzahl and counter absent; no other behaviour changes.
// TESTING
//   1 Reset=0 for 2 cycles mid-DEKODIERT with Belegt[5]=1
//     -> all outputs 0; after release state BEREIT, Belegt=0, FetchBereit=1.
//   2 Load Z=5, then add Q1=5 with no writeback
//     -> add stalls; Stall=1 each cycle; AusfuehrenSignal only after RueckschreibGueltig, Register=5.
//   3 Add Q1=5 stalled; RueckschreibGueltig, Register=5 in the same cycle
//     -> AusfuehrenSignal=1 that cycle (bypass); Belegt[5]=0 afterwards.
//   4 Store with Z=7, then read r7
//     -> no stall; Belegt[7] stays 0. JAL Z=31 -> Belegt[31]=1, state SPRUNG.
//   5 Bez issued -> FetchBereit=0 for 4 cycles with InstruktionGueltig=1;
//     SprungAufgeloest in cycle 5 -> DekodierSignal next cycle.
//   6 Writeback r9 in the same cycle as issue of a load with Z=9 -> Belegt[9]=1.
//     With STALL_ZAEHLER_EN: 3 stall cycles -> StallAnzahl=3.

Source files
------------

// File: rtl/dekodier_steuerwerk.sv
// dekodier_steuerwerk: issue sequencer between fetch, decoder and execute
//   Accepts fetched words, holds the decoded instruction until its source and
//   target registers are free in a REG_ANZAHL-entry scoreboard, issues it, and
//   blocks fetch while a jump is unresolved.
//   Optional macro STALL_ZAEHLER_EN adds a saturating stall-cycle counter.
// Ports:
//   Clock, Reset               clock; synchronous active-low reset
//   InstruktionGueltig         fetch presents a valid word
//   FetchBereit                controller can accept a word this cycle
//   DekodierSignal             decoder latches the word at this edge
//   QuellRegister1/2, ZielRegister   decoder register indices
//   LoadBefehl .. BedingterSprungBefehl   decoder class flags
//   AusfuehrenSignal           one-cycle issue pulse to execute
//   Stall                      decoded instruction held by a hazard
//   RueckschreibGueltig/Register     writeback clears a scoreboard entry
//   SprungAufgeloest           execute resolved the outstanding jump
//   StallAnzahl                stall-cycle count (STALL_ZAEHLER_EN only)
module dekodier_steuerwerk #(
    parameter int REG_ANZAHL = 64,
    parameter int ZAEHLER_BREITE = 32,
    localparam int IW = $clog2(REG_ANZAHL)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          InstruktionGueltig,
    output logic          FetchBereit,
    output logic          DekodierSignal,
    input  logic [IW-1:0] QuellRegister1,
    input  logic [IW-1:0] QuellRegister2,
    input  logic [IW-1:0] ZielRegister,
    input  logic          LoadBefehl,
    input  logic          StoreBefehl,
    input  logic          JALBefehl,
    input  logic          UnbedingterSprungBefehl,
    input  logic          BedingterSprungBefehl,
    output logic          AusfuehrenSignal,
    output logic          Stall,
    input  logic          RueckschreibGueltig,
    input  logic [IW-1:0] RueckschreibRegister,
    input  logic          SprungAufgeloest
`ifdef STALL_ZAEHLER_EN
    ,
    output logic [ZAEHLER_BREITE-1:0] StallAnzahl
`endif
);
    typedef enum logic [1:0] {BEREIT, DEKODIERT, SPRUNG} zustandT;
    zustandT zustand;
    logic [REG_ANZAHL-1:0] belegt, belegtEff, loeschMaske, setzMaske;
    logic hazard, sprung, reserviert;
    logic unusedLoad;
    assign unusedLoad = LoadBefehl;
    always_comb begin
        // The writeback clear is bypassed so an instruction can issue in the writeback cycle
        loeschMaske = RueckschreibGueltig ? (REG_ANZAHL'(1) << RueckschreibRegister) : '0;
        belegtEff = belegt & ~loeschMaske;
        hazard = belegtEff[QuellRegister1] | belegtEff[QuellRegister2] | belegtEff[ZielRegister];
        sprung = UnbedingterSprungBefehl | BedingterSprungBefehl;
        FetchBereit = Reset && zustand == BEREIT;
        DekodierSignal = FetchBereit && InstruktionGueltig;
        Stall = Reset && zustand == DEKODIERT && hazard;
        AusfuehrenSignal = Reset && zustand == DEKODIERT && !hazard;
        // Stores and plain jumps write no register; JAL reserves its link register
        reserviert = AusfuehrenSignal && ZielRegister != '0 && !StoreBefehl && !(sprung && !JALBefehl);
        setzMaske = reserviert ? (REG_ANZAHL'(1) << ZielRegister) : '0;
    end
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            zustand <= BEREIT;
            belegt <= '0;
        end else begin
            belegt <= belegtEff | setzMaske;
            zustand <= zustand == BEREIT ? (InstruktionGueltig ? DEKODIERT : BEREIT)
                     : zustand == DEKODIERT ? (hazard ? DEKODIERT : sprung ? SPRUNG : BEREIT)
                     : SprungAufgeloest ? BEREIT : SPRUNG;
        end
    end
`ifdef STALL_ZAEHLER_EN
    logic [ZAEHLER_BREITE-1:0] zaehler;
    always_ff @(posedge Clock) begin
        if (!Reset)
            zaehler <= '0;
        else if (Stall && !(&zaehler))
            zaehler <= zaehler + ZAEHLER_BREITE'(1);
    end
    assign StallAnzahl = Reset ? zaehler : '0;
`else
    logic [ZAEHLER_BREITE-1:0] unusedZaehler;
    assign unusedZaehler = '0;
`endif
endmodule

// File: tb/tb_dekodier_steuerwerk.sv
// tb_dekodier_steuerwerk: directed vector table plus randomized run against a reference model
module tb_dekodier_steuerwerk;
    logic Clock = 0, Reset = 0, InstruktionGueltig = 0;
    logic FetchBereit, DekodierSignal, AusfuehrenSignal, Stall;
    logic [5:0] QuellRegister1 = 0, QuellRegister2 = 0, ZielRegister = 0, RueckschreibRegister = 0;
    logic LoadBefehl = 0, StoreBefehl = 0, JALBefehl = 0, UnbedingterSprungBefehl = 0, BedingterSprungBefehl = 0;
    logic RueckschreibGueltig = 0, SprungAufgeloest = 0;
`ifdef STALL_ZAEHLER_EN
    logic [31:0] StallAnzahl;
`endif

    dekodier_steuerwerk dut (
        .Clock(Clock), .Reset(Reset), .InstruktionGueltig(InstruktionGueltig),
        .FetchBereit(FetchBereit), .DekodierSignal(DekodierSignal),
        .QuellRegister1(QuellRegister1), .QuellRegister2(QuellRegister2), .ZielRegister(ZielRegister),
        .LoadBefehl(LoadBefehl), .StoreBefehl(StoreBefehl), .JALBefehl(JALBefehl),
        .UnbedingterSprungBefehl(UnbedingterSprungBefehl), .BedingterSprungBefehl(BedingterSprungBefehl),
        .AusfuehrenSignal(AusfuehrenSignal), .Stall(Stall),
        .RueckschreibGueltig(RueckschreibGueltig), .RueckschreibRegister(RueckschreibRegister),
        .SprungAufgeloest(SprungAufgeloest)
`ifdef STALL_ZAEHLER_EN
        , .StallAnzahl(StallAnzahl)
`endif
    );

    always #5 Clock = ~Clock;

    // class flags {load, store, jal, unconditional jump, conditional jump}
    localparam logic [4:0] ALU = 5'b00000, LD = 5'b10000, ST = 5'b01000,
                           JL = 5'b00110, JP = 5'b00010, BZ = 5'b00001;

    // expected outputs packed as {FetchBereit, DekodierSignal, AusfuehrenSignal, Stall}
    typedef struct {
        logic rst, iv;
        logic [5:0] q1, q2, z;
        logic [4:0] cls;
        logic wbv;
        logic [5:0] wbr;
        logic sa;
        logic [3:0] erw;
    } vecT;

    vecT tab[$];
    int checks = 0, errors = 0;

    bit mBusy[64];
    bit mHalten, mSprung;
    longint mCnt;

    function automatic vecT v(logic rst, logic iv, logic [5:0] q1, logic [5:0] q2, logic [5:0] z,
                              logic [4:0] cls, logic wbv, logic [5:0] wbr, logic sa, logic [3:0] erw);
        return '{rst, iv, q1, q2, z, cls, wbv, wbr, sa, erw};
    endfunction

    function automatic vecT zufall();
        vecT t;
        logic [4:0] k [6] = '{ALU, LD, ST, JL, JP, BZ};
        t.rst = $urandom_range(0, 59) != 0;
        t.iv = $urandom_range(0, 3) != 0;
        t.q1 = 6'($urandom_range(0, 7));
        t.q2 = 6'($urandom_range(0, 7));
        t.z = 6'($urandom_range(0, 7));
        t.cls = k[$urandom_range(0, 5)];
        t.wbv = $urandom_range(0, 2) == 0;
        t.wbr = 6'($urandom_range(0, 7));
        t.sa = $urandom_range(0, 3) == 0;
        t.erw = 0;
        return t;
    endfunction

    task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
        checks++;
        if (ist !== soll) begin
            errors++;
            $display("FAIL %s ist=%0h soll=%0h", name, ist, soll);
        end
    endtask

    // Reference: an instruction is either absent, waiting for its registers, or done;
    // a taken jump blocks fetch until resolved. Expected outputs come from the
    // state before the edge, then the model advances by one cycle.
    task automatic modellSchritt(output logic [3:0] erw, output logic [31:0] ecnt);
        bit eff[64];
        bit bereit, hz, aus, istSprung;
        if (!Reset) begin
            erw = 0;
            ecnt = 0;
            mBusy = '{default: 0};
            mHalten = 0;
            mSprung = 0;
            mCnt = 0;
        end else begin
            eff = mBusy;
            if (RueckschreibGueltig) eff[RueckschreibRegister] = 0;
            bereit = !mHalten && !mSprung;
            hz = mHalten && (eff[QuellRegister1] || eff[QuellRegister2] || eff[ZielRegister]);
            aus = mHalten && !hz;
            erw = {bereit, bereit && InstruktionGueltig, aus, hz};
            ecnt = 32'(mCnt);
            istSprung = UnbedingterSprungBefehl || BedingterSprungBefehl;
            mBusy = eff;
            if (aus && ZielRegister != 0 && !StoreBefehl && !(istSprung && !JALBefehl))
                mBusy[ZielRegister] = 1;
            if (hz && mCnt < 64'hFFFF_FFFF) mCnt++;
            if (aus) begin
                mHalten = 0;
                mSprung = istSprung;
            end else if (mSprung && SprungAufgeloest)
                mSprung = 0;
            if (bereit && InstruktionGueltig) mHalten = 1;
        end
    endtask

    task automatic zyklus(input vecT t, input bit ausTabelle, input string name);
        logic [3:0] erw;
        logic [31:0] ecnt;
        @(negedge Clock);
        Reset = t.rst;
        InstruktionGueltig = t.iv;
        QuellRegister1 = t.q1;
        QuellRegister2 = t.q2;
        ZielRegister = t.z;
        {LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl} = t.cls;
        RueckschreibGueltig = t.wbv;
        RueckschreibRegister = t.wbr;
        SprungAufgeloest = t.sa;
        #1;
        modellSchritt(erw, ecnt);
        pruefe(name, 32'({FetchBereit, DekodierSignal, AusfuehrenSignal, Stall}), 32'(ausTabelle ? t.erw : erw));
`ifdef STALL_ZAEHLER_EN
        pruefe({name, "_stallAnzahl"}, StallAnzahl, ecnt);
`endif
    endtask

    initial begin
        vecT t;
        logic [3:0] erw;
        logic [31:0] ecnt;
        // reset
        tab.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 0, 4'b0000));
        // load r5, then add reading r5 stalls until writeback r5 (bypassed)
        tab.push_back(v(1, 1, 0, 0, 5, LD, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 0, 0, 5, LD, 0, 0, 0, 4'b0010));
        tab.push_back(v(1, 1, 5, 0, 0, ALU, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 0, 0, 0, 4'b0001));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 0, 0, 0, 4'b0001));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 1, 5, 0, 4'b0010));
        tab.push_back(v(1, 1, 5, 0, 0, ALU, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 0, 0, 0, 4'b0010));
        // reset for two cycles while stalled with r5 busy
        tab.push_back(v(1, 1, 0, 0, 5, LD, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 0, 0, 5, LD, 0, 0, 0, 4'b0010));
        tab.push_back(v(1, 1, 5, 0, 0, ALU, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 0, 0, 0, 4'b0001));
        tab.push_back(v(0, 1, 5, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(0, 1, 5, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 0, 0, 0, 4'b1000));
        tab.push_back(v(1, 1, 5, 0, 0, ALU, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 5, 0, 0, ALU, 0, 0, 0, 4'b0010));
        // store r7 reserves nothing; JAL r31 reserves and enters jump wait
        tab.push_back(v(1, 1, 0, 0, 7, ST, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 0, 0, 7, ST, 0, 0, 0, 4'b0010));
        tab.push_back(v(1, 1, 7, 0, 0, ALU, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 7, 0, 0, ALU, 0, 0, 0, 4'b0010));
        tab.push_back(v(1, 1, 0, 0, 31, JL, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 0, 0, 31, JL, 0, 0, 0, 4'b0010));
        tab.push_back(v(1, 1, 0, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(1, 1, 0, 0, 0, ALU, 0, 0, 1, 4'b0000));
        tab.push_back(v(1, 1, 31, 0, 0, ALU, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 31, 0, 0, ALU, 0, 0, 0, 4'b0001));
        tab.push_back(v(1, 0, 31, 0, 0, ALU, 1, 31, 0, 4'b0010));
        // Bez: fetch blocked until resolve, accepted the cycle after
        tab.push_back(v(1, 1, 0, 0, 0, BZ, 0, 0, 0, 4'b1100));
        tab.push_back(v(1, 0, 1, 0, 0, BZ, 0, 0, 0, 4'b0010));
        for (int i = 0; i < 4; i++) tab.push_back(v(1, 1, 0, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(1, 1, 0, 0, 0, ALU, 0, 0, 1, 4'b0000));
        tab.push_back(v(1, 1, 0, 0, 0, ALU, 0, 0, 1, 4'b1100));
        tab.push_back(v(1, 0, 0, 0, 0, ALU, 0, 0, 1, 4'b0010));
        // reset, then writeback r9 in the issue cycle of load r9: set wins
        tab.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 0, 4'b0000));
        tab.push_back(v(1, 1, 0, 0, 9, LD, 1, 9, 0, 4'b1100));
        tab.push_back(v(1, 0, 0, 0, 9, LD, 1, 9, 0, 4'b0010));
        tab.push_back(v(1, 1, 0, 9, 0, ALU, 0, 0, 0, 4'b1100));
        for (int i = 0; i < 3; i++) tab.push_back(v(1, 0, 0, 9, 0, ALU, 0, 0, 0, 4'b0001));
        tab.push_back(v(1, 0, 0, 9, 0, ALU, 1, 9, 0, 4'b0010));

        for (int i = 0; i < tab.size(); i++) zyklus(tab[i], 1, $sformatf("vektor%0d", i));
`ifdef STALL_ZAEHLER_EN
        @(negedge Clock);
        #1;
        pruefe("stallAnzahlNachDrei", StallAnzahl, 32'd3);
        modellSchritt(erw, ecnt);
`endif
        for (int i = 0; i < 3000; i++) begin
            t = zufall();
            zyklus(t, 0, $sformatf("zufall%0d", i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
